// File: rtl/uart_pkg.sv
// uart_pkg: shared UART TX state encodings, parity/data-length codes and frame helpers
package uart_pkg;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} tx_state_e;
  localparam logic [1:0] PAR_NONE = 2'b00;
  localparam logic [1:0] PAR_EVEN = 2'b01;
  localparam logic [1:0] PAR_ODD  = 2'b10;
  localparam logic [1:0] DB_5 = 2'b00;
  localparam logic [1:0] DB_6 = 2'b01;
  localparam logic [1:0] DB_7 = 2'b10;
  localparam logic [1:0] DB_8 = 2'b11;
  function automatic logic [3:0] data_len(input logic [1:0] code);
    return 4'd5 + {2'b00, code};
  endfunction
  function automatic logic [7:0] data_mask(input logic [1:0] code);
    return 8'hFF >> (2'd3 - code);
  endfunction
  function automatic logic par_bit(input logic [7:0] b, input logic [1:0] db, input logic [1:0] par);
    return (^(b & data_mask(db))) ^ (par == PAR_ODD);
  endfunction
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: synchronous byte FIFO (push/pop, head read, registered count, full/empty)
module uart_tx_fifo #(
  parameter int FIFO_DEPTH = 8
) (
  input  logic                          i_Clock,
  input  logic                          i_Reset,
  input  logic                          push,
  input  logic [7:0]                    wr_data,
  input  logic                          pop,
  output logic [7:0]                    rd_data,
  output logic [$clog2(FIFO_DEPTH):0]   count,
  output logic                          full,
  output logic                          empty
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic          do_push, do_pop;
  assign full    = count == CW'(FIFO_DEPTH);
  assign empty   = count == '0;
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rd_data = mem[rd_ptr];
  always_ff @(posedge i_Clock)
    if (do_push) mem[wr_ptr] <= wr_data;
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(do_push) - CW'(do_pop);
    end
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: runtime-configurable UART TX (div, 5-8 bits, parity, stop) fed by a byte FIFO; bus write side in, o_Tx_Serial out
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_DIV_W  = 16,
  parameter int FIFO_DEPTH = 8
) (
  input  logic                        i_Clock,
  input  logic                        i_Reset,
  input  logic [CLK_DIV_W-1:0]        i_Cfg_Div,
  input  logic [1:0]                  i_Cfg_Data_Bits,
  input  logic [1:0]                  i_Cfg_Parity,
  input  logic                        i_Cfg_Stop2,
  input  logic                        i_Tx_DV,
  input  logic [7:0]                  i_Tx_Byte,
  output logic                        o_Tx_Ready,
  output logic [$clog2(FIFO_DEPTH):0] o_Fifo_Count,
  output logic                        o_Tx_Serial,
  output logic                        o_Tx_Active,
  output logic                        o_Tx_Done
);
  tx_state_e            state;
  logic [CLK_DIV_W-1:0] div_r, clk_cnt;
  logic [7:0]           sh, head;
  logic [2:0]           last_r, bit_idx;
  logic                 par_en, par_val, stop2_r, stop_cnt;
  logic                 full, empty, tick, last_stop, pop;
  assign tick       = clk_cnt == div_r - 1'b1;
  assign last_stop  = tick && (!stop2_r || stop_cnt);
  assign pop        = !empty && (state == S_IDLE || (state == S_STOP && last_stop));
  assign o_Tx_Ready = !full;
  uart_tx_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .i_Clock (i_Clock),
    .i_Reset (i_Reset),
    .push    (i_Tx_DV),
    .wr_data (i_Tx_Byte),
    .pop     (pop),
    .rd_data (head),
    .count   (o_Fifo_Count),
    .full    (full),
    .empty   (empty)
  );
  always_ff @(posedge i_Clock or negedge i_Reset)
    if (!i_Reset) begin
      state       <= S_IDLE;
      div_r       <= '0;
      clk_cnt     <= '0;
      sh          <= '0;
      last_r      <= '0;
      bit_idx     <= '0;
      par_en      <= 1'b0;
      par_val     <= 1'b0;
      stop2_r     <= 1'b0;
      stop_cnt    <= 1'b0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done   <= 1'b0;
    end else begin
      o_Tx_Done <= 1'b0;
      clk_cnt   <= (state == S_IDLE || tick) ? '0 : clk_cnt + 1'b1;
      case (state)
        S_START: if (tick) begin
          state       <= S_DATA;
          o_Tx_Serial <= sh[0];
          sh          <= sh >> 1;
        end
        S_DATA: if (tick) begin
          if (bit_idx == last_r) begin
            state       <= par_en ? S_PARITY : S_STOP;
            o_Tx_Serial <= par_en ? par_val : 1'b1;
            stop_cnt    <= 1'b0;
          end else begin
            bit_idx     <= bit_idx + 1'b1;
            o_Tx_Serial <= sh[0];
            sh          <= sh >> 1;
          end
        end
        S_PARITY: if (tick) begin
          state       <= S_STOP;
          o_Tx_Serial <= 1'b1;
          stop_cnt    <= 1'b0;
        end
        S_STOP: if (tick) begin
          if (!last_stop) stop_cnt <= 1'b1;
          else begin
            o_Tx_Done   <= 1'b1;
            state       <= S_IDLE;
            o_Tx_Active <= 1'b0;
            o_Tx_Serial <= 1'b1;
          end
        end
        default: begin
          o_Tx_Serial <= 1'b1;
          o_Tx_Active <= 1'b0;
        end
      endcase
      if (pop) begin
        state       <= S_START;
        o_Tx_Serial <= 1'b0;
        o_Tx_Active <= 1'b1;
        sh          <= head;
        div_r       <= (i_Cfg_Div == '0) ? CLK_DIV_W'(1) : i_Cfg_Div;
        last_r      <= 3'(data_len(i_Cfg_Data_Bits) - 4'd1);
        par_en      <= i_Cfg_Parity == PAR_EVEN || i_Cfg_Parity == PAR_ODD;
        par_val     <= par_bit(head, i_Cfg_Data_Bits, i_Cfg_Parity);
        stop2_r     <= i_Cfg_Stop2;
        bit_idx     <= '0;
        clk_cnt     <= '0;
        stop_cnt    <= 1'b0;
      end
    end
endmodule
